// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand/result bus for the
// bit-serial subtractor. The controller side uses the master modport and the
// subtractor uses the slave modport.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the overflow flag V.
interface serial_subtractor_if #(
   parameter int unsigned WIDTH = 4
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] D;
   logic             Bout;
`ifdef SERIAL_SUB_OVF_EN
   logic             V;

   modport master (
      output start, A, B, Bin,
      input  busy, done, D, Bout, V
   );

   modport slave (
      input  start, A, B, Bin,
      output busy, done, D, Bout, V
   );
`else
   modport master (
      output start, A, B, Bin,
      input  busy, done, D, Bout
   );

   modport slave (
      input  start, A, B, Bin,
      output busy, done, D, Bout
   );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, D = A - B - Bin, one bit per
// clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
// An accepted start latches the operands; WIDTH SHIFT cycles later the result is
// presented with a one-cycle done pulse and held until the next accepted start.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the two's-complement overflow
// flag V (borrow into MSB xor borrow out), updated together with D.
module serial_subtractor #(
   parameter int unsigned WIDTH = 4
) (
   input logic                clk,
   input logic                rst_n,
   serial_subtractor_if.slave bus
);

   localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] ar_q;      // minuend shift register
   logic [WIDTH-1:0] br_q;      // subtrahend shift register
   logic [WIDTH-1:0] res_q;     // result assembly, filled from the MSB end
   logic [CntW-1:0]  cnt_q;
   logic             borrow_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] d_q;
   logic             bout_q;

   logic             a_bit;
   logic             b_bit;
   logic             d_bit;
   logic             borrow_nxt;
   logic [WIDTH-1:0] res_nxt;

`ifdef SERIAL_SUB_OVF_EN
   logic             v_q;
`endif

   // Full-subtractor cell on the current LSBs and the running borrow.
   always_comb begin
      a_bit      = ar_q[0];
      b_bit      = br_q[0];
      d_bit      = a_bit ^ b_bit ^ borrow_q;
      borrow_nxt = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);
      res_nxt    = {d_bit, res_q[WIDTH-1:1]};
   end

   // Control FSM and datapath registers; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         ar_q     <= '0;
         br_q     <= '0;
         res_q    <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         d_q      <= '0;
         bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         v_q      <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            StShift: begin
               // start and operand inputs are deliberately not looked at here
               ar_q     <= {1'b0, ar_q[WIDTH-1:1]};
               br_q     <= {1'b0, br_q[WIDTH-1:1]};
               res_q    <= res_nxt;
               borrow_q <= borrow_nxt;
               cnt_q    <= cnt_q + CntW'(1);
               if (cnt_q == LastCnt) begin
                  state_q <= StDone;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  d_q     <= res_nxt;
                  bout_q  <= borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
                  // borrow_q is the borrow into the MSB while the MSB is processed
                  v_q     <= borrow_q ^ borrow_nxt;
`endif
               end
            end
            // StIdle, StDone and any illegal encoding: accept a new request or rest
            default: begin
               busy_q <= 1'b0;
               if (bus.start) begin
                  state_q  <= StShift;
                  ar_q     <= bus.A;
                  br_q     <= bus.B;
                  borrow_q <= bus.Bin;
                  res_q    <= '0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
               end else begin
                  state_q <= StIdle;
               end
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.D    = d_q;
   assign bus.Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
   assign bus.V    = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed vectors for the 4-bit serial subtractor with
// hand-computed results; V is checked only when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

   localparam int unsigned W = 4;

   logic clk;
   logic rst_n;
   int   nerr;
   int   nchk;
   int   n;
   int   done_cnt;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_v(input string tag, input logic ev);
`ifdef SERIAL_SUB_OVF_EN
      check(tag, 32'(bus.V), 32'(ev));
`else
      if (ev === 1'bx) $display("unused %s", tag);
`endif
   endtask

   // One complete operation: pulse start, wait (bounded) for done, check results.
   task automatic do_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic bin, input logic [3:0] ed, input logic eb,
                        input logic ev);
      int k;
      bus.A     = a;
      bus.B     = b;
      bus.Bin   = bin;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      k = 0;
      while (bus.done !== 1'b1 && k < 20) begin
         tick();
         k++;
      end
      check({tag, "_lat"}, 32'(k), 32'(W));
      check({tag, "_D"}, 32'(bus.D), 32'(ed));
      check({tag, "_Bout"}, 32'(bus.Bout), 32'(eb));
      check({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
      check_v({tag, "_V"}, ev);
      tick();
      check({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
      check({tag, "_D_held"}, 32'(bus.D), 32'(ed));
   endtask

   initial begin
      nerr      = 0;
      nchk      = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.A     = '0;
      bus.B     = '0;
      bus.Bin   = 1'b0;
      tick();
      tick();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_D", 32'(bus.D), 32'd0);
      check("rst_Bout", 32'(bus.Bout), 32'd0);
      check_v("rst_V", 1'b0);
      rst_n = 1'b1;
      tick();

      // Basic, positive and negative differences, wrap-around
      do_op("zero",  4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      do_op("a10b5", 4'b1010, 4'b0101, 1'b0, 4'b0101, 1'b0, 1'b1);
      do_op("a9b6",  4'b1001, 4'b0110, 1'b0, 4'b0011, 1'b0, 1'b1);
      do_op("a5b10", 4'b0101, 4'b1010, 1'b0, 4'b1011, 1'b1, 1'b1);
      do_op("wrap",  4'b0000, 4'b0000, 1'b1, 4'b1111, 1'b1, 1'b0);

      // Reset two cycles into SHIFT aborts the operation
      bus.A     = 4'b0111;
      bus.B     = 4'b0001;
      bus.Bin   = 1'b0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_done", 32'(bus.done), 32'd0);
      check("abort_D", 32'(bus.D), 32'd0);
      check("abort_Bout", 32'(bus.Bout), 32'd0);
      done_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (bus.done === 1'b1) done_cnt++;
      end
      check("abort_no_done", 32'(done_cnt), 32'd0);
      do_op("after_rst", 4'b0111, 4'b0001, 1'b0, 4'b0110, 1'b0, 1'b0);

      // start held through SHIFT with changing operands, then back-to-back from DONE
      bus.A     = 4'b1100;
      bus.B     = 4'b0011;
      bus.Bin   = 1'b0;
      bus.start = 1'b1;
      tick();
      check("hold_busy", 32'(bus.busy), 32'd1);
      for (int i = 1; i <= 3; i++) begin
         bus.A   = 4'(i * 3);
         bus.B   = 4'(i * 5);
         bus.Bin = 1'(i);
         tick();
         check("hold_nodone", 32'(bus.done), 32'd0);
      end
      bus.A   = 4'b1111;
      bus.B   = 4'b1111;
      bus.Bin = 1'b0;
      tick();
      check("hold_done", 32'(bus.done), 32'd1);
      check("hold_D", 32'(bus.D), 32'b1001);
      check("hold_Bout", 32'(bus.Bout), 32'd0);
      check_v("hold_V", 1'b0);
      tick();
      bus.start = 1'b0;
      check("b2b_busy", 32'(bus.busy), 32'd1);
      check("b2b_done_low", 32'(bus.done), 32'd0);
      n = 0;
      while (bus.done !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check("b2b_lat", 32'(n), 32'(W));
      check("b2b_D", 32'(bus.D), 32'b0000);
      check("b2b_Bout", 32'(bus.Bout), 32'd0);
      check_v("b2b_V", 1'b0);
      tick();

      // Signed-overflow vectors
      do_op("ovf1", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);
      do_op("ovf0", 4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
